// File: rtl/uart_fifo.sv
// Byte buffering between the b16 I/O bus and the auto-bauding UART core.
// A show-ahead RX FIFO feeds the host; a paced TX engine spaces start pulses one frame apart.
module uart_fifo #(
  parameter int DEPTH_LOG2 = 4
) (
  input  logic                  clk,
  input  logic                  nreset,
  input  logic [7:0]            uart_id,
  input  logic                  uart_dix,
  input  logic [7:0]            uart_rate,
  output logic [7:0]            uart_od,
  output logic                  uart_dox,
  input  logic [7:0]            wr_data,
  input  logic                  wr_en,
  output logic                  tx_full,
  output logic [DEPTH_LOG2:0]   tx_count,
  output logic [7:0]            rd_data,
  input  logic                  rd_en,
  output logic                  rx_empty,
  output logic [DEPTH_LOG2:0]   rx_count,
  output logic                  rx_overrun,
  input  logic                  ovr_clr
);

  localparam int DEPTH = 1 << DEPTH_LOG2;
  localparam int CW    = DEPTH_LOG2 + 1;

  typedef enum logic {IDLE, GAP} tx_state_t;

  // RX FIFO
  logic [7:0]            rx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] rx_wp_q, rx_rp_q;
  logic [CW-1:0]         rx_cnt_q, rx_cnt_d;
  logic                  rx_ovr_q, rx_ovr_d;
  logic                  rx_full, rx_push, rx_pop, rx_drop;

  assign rx_full  = (rx_cnt_q == CW'(DEPTH));
  assign rx_pop   = rd_en && (rx_cnt_q != '0);
  // A strobe into a full FIFO still lands if the host frees the head slot on the same edge.
  assign rx_push  = uart_dix && (!rx_full || rd_en);
  assign rx_drop  = uart_dix && rx_full && !rd_en;

  always_comb begin
    rx_cnt_d = rx_cnt_q;
    case ({rx_push, rx_pop})
      2'b10:   rx_cnt_d = rx_cnt_q + CW'(1);
      2'b01:   rx_cnt_d = rx_cnt_q - CW'(1);
      default: rx_cnt_d = rx_cnt_q;
    endcase
    rx_ovr_d = rx_ovr_q;
    if (ovr_clr) rx_ovr_d = 1'b0;
    if (rx_drop) rx_ovr_d = 1'b1;
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      rx_wp_q  <= '0;
      rx_rp_q  <= '0;
      rx_cnt_q <= '0;
      rx_ovr_q <= 1'b0;
    end else begin
      if (rx_push) rx_wp_q <= rx_wp_q + DEPTH_LOG2'(1);
      if (rx_pop)  rx_rp_q <= rx_rp_q + DEPTH_LOG2'(1);
      rx_cnt_q <= rx_cnt_d;
      rx_ovr_q <= rx_ovr_d;
    end
  end

  always_ff @(posedge clk) begin
    if (rx_push) rx_mem[rx_wp_q] <= uart_id;
  end

  assign rd_data    = rx_mem[rx_rp_q];
  assign rx_empty   = (rx_cnt_q == '0);
  assign rx_count   = rx_cnt_q;
  assign rx_overrun = rx_ovr_q;

  // TX FIFO
  logic [7:0]            tx_mem [DEPTH];
  logic [DEPTH_LOG2-1:0] tx_wp_q, tx_rp_q;
  logic [CW-1:0]         tx_cnt_q, tx_cnt_d;
  logic                  tx_full_w, tx_push, tx_start;
  tx_state_t             state_q;

  assign tx_full_w = (tx_cnt_q == CW'(DEPTH));
  assign tx_start  = (state_q == IDLE) && (tx_cnt_q != '0) && (uart_rate != 8'd0);
  assign tx_push   = wr_en && (!tx_full_w || tx_start);

  always_comb begin
    tx_cnt_d = tx_cnt_q;
    case ({tx_push, tx_start})
      2'b10:   tx_cnt_d = tx_cnt_q + CW'(1);
      2'b01:   tx_cnt_d = tx_cnt_q - CW'(1);
      default: tx_cnt_d = tx_cnt_q;
    endcase
  end

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      tx_wp_q  <= '0;
      tx_rp_q  <= '0;
      tx_cnt_q <= '0;
    end else begin
      if (tx_push)  tx_wp_q <= tx_wp_q + DEPTH_LOG2'(1);
      if (tx_start) tx_rp_q <= tx_rp_q + DEPTH_LOG2'(1);
      tx_cnt_q <= tx_cnt_d;
    end
  end

  always_ff @(posedge clk) begin
    if (tx_push) tx_mem[tx_wp_q] <= wr_data;
  end

  assign tx_full  = tx_full_w;
  assign tx_count = tx_cnt_q;

  // TX pacing engine: one bit period is (rate+1)*8 clocks, frame hold-off is 11 bit periods
  logic [11:0] tmr_q;
  logic [3:0]  bit_q;
  logic [7:0]  od_q;
  logic        dox_q;
  logic [11:0] bit_len;

  assign bit_len = 12'(({4'd0, uart_rate} + 12'd1) << 3);

  always_ff @(posedge clk or negedge nreset) begin
    if (!nreset) begin
      state_q <= IDLE;
      tmr_q   <= '0;
      bit_q   <= '0;
      od_q    <= '0;
      dox_q   <= 1'b0;
    end else begin
      case (state_q)
        IDLE: begin
          dox_q <= 1'b0;
          if (tx_start) begin
            od_q    <= tx_mem[tx_rp_q];
            dox_q   <= 1'b1;
            bit_q   <= '0;
            tmr_q   <= bit_len;
            state_q <= GAP;
          end
        end
        GAP: begin
          dox_q <= 1'b0;
          // Leave one clock early so the IDLE dispatch cycle closes out the guard bit.
          if (bit_q == 4'd10 && tmr_q == 12'd2) begin
            state_q <= IDLE;
            tmr_q   <= '0;
            bit_q   <= '0;
          end else if (tmr_q == 12'd1) begin
            tmr_q <= bit_len;
            bit_q <= bit_q + 4'd1;
          end else begin
            tmr_q <= tmr_q - 12'd1;
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  assign uart_od  = od_q;
  assign uart_dox = dox_q;

endmodule

// File: tb/tb_uart_fifo.sv
// Directed bench for uart_fifo: RX ordering/overrun, TX baud-lock gate, frame pacing, reset mid-frame.
module tb_uart_fifo;

  logic       clk = 1'b0;
  logic       nreset = 1'b0;
  logic [7:0] uart_id = '0;
  logic       uart_dix = 1'b0;
  logic [7:0] uart_rate = '0;
  logic [7:0] uart_od;
  logic       uart_dox;
  logic [7:0] wr_data = '0;
  logic       wr_en = 1'b0;
  logic       tx_full;
  logic [4:0] tx_count;
  logic [7:0] rd_data;
  logic       rd_en = 1'b0;
  logic       rx_empty;
  logic [4:0] rx_count;
  logic       rx_overrun;
  logic       ovr_clr = 1'b0;

  int total  = 0;
  int passed = 0;

  uart_fifo #(.DEPTH_LOG2(4)) dut (
    .clk(clk), .nreset(nreset),
    .uart_id(uart_id), .uart_dix(uart_dix), .uart_rate(uart_rate),
    .uart_od(uart_od), .uart_dox(uart_dox),
    .wr_data(wr_data), .wr_en(wr_en), .tx_full(tx_full), .tx_count(tx_count),
    .rd_data(rd_data), .rd_en(rd_en), .rx_empty(rx_empty), .rx_count(rx_count),
    .rx_overrun(rx_overrun), .ovr_clr(ovr_clr)
  );

  always #5 clk = ~clk;

  task automatic tick();
    @(posedge clk);
    #1;
  endtask

  task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    total++;
    assert (obs === exp) passed++;
    else $error("FAIL %s observed=0x%0h expected=0x%0h", tag, obs, exp);
  endtask

  int n;
  int bad;
  int pulses;

  initial begin
    // Reset
    nreset = 1'b0;
    repeat (3) tick();
    nreset = 1'b1;
    tick();
    chk("rst_rx_empty", 32'(rx_empty), 32'd1);
    chk("rst_rx_count", 32'(rx_count), 32'd0);
    chk("rst_tx_count", 32'(tx_count), 32'd0);
    chk("rst_tx_full", 32'(tx_full), 32'd0);
    chk("rst_dox", 32'(uart_dox), 32'd0);
    chk("rst_od", 32'(uart_od), 32'd0);
    chk("rst_overrun", 32'(rx_overrun), 32'd0);

    // RX ordering
    for (int b = 8'h41; b <= 8'h43; b++) begin
      uart_id = 8'(b); uart_dix = 1'b1; tick();
    end
    uart_dix = 1'b0;
    chk("rx3_count", 32'(rx_count), 32'd3);
    chk("rx3_head", 32'(rd_data), 32'h41);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rx_pop1", 32'(rd_data), 32'h42);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rx_pop2", 32'(rd_data), 32'h43);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rx_drained_empty", 32'(rx_empty), 32'd1);
    rd_en = 1'b1; tick(); rd_en = 1'b0;
    chk("rx_extra_pop_count", 32'(rx_count), 32'd0);
    chk("rx_extra_pop_empty", 32'(rx_empty), 32'd1);

    // RX overrun: 17 strobes, no reads
    for (int b = 0; b < 17; b++) begin
      uart_id = 8'(b); uart_dix = 1'b1; tick();
    end
    uart_dix = 1'b0;
    chk("ovr_count", 32'(rx_count), 32'd16);
    chk("ovr_flag", 32'(rx_overrun), 32'd1);
    bad = 0;
    for (int b = 0; b < 16; b++) begin
      if (rd_data !== 8'(b)) bad++;
      rd_en = 1'b1; tick(); rd_en = 1'b0;
    end
    chk("ovr_readback_errors", 32'(bad), 32'd0);
    chk("ovr_flag_sticky", 32'(rx_overrun), 32'd1);
    ovr_clr = 1'b1; tick(); ovr_clr = 1'b0;
    chk("ovr_cleared", 32'(rx_overrun), 32'd0);

    // Full FIFO with simultaneous strobe and read
    for (int b = 0; b < 16; b++) begin
      uart_id = 8'(8'h20 + b); uart_dix = 1'b1; tick();
    end
    uart_id = 8'h99; uart_dix = 1'b1; rd_en = 1'b1; tick();
    uart_dix = 1'b0; rd_en = 1'b0;
    chk("full_rw_count", 32'(rx_count), 32'd16);
    chk("full_rw_no_ovr", 32'(rx_overrun), 32'd0);
    chk("full_rw_head", 32'(rd_data), 32'h21);
    // Set beats clear in the same cycle
    uart_dix = 1'b1; ovr_clr = 1'b1; tick();
    uart_dix = 1'b0; ovr_clr = 1'b0;
    chk("ovr_set_wins", 32'(rx_overrun), 32'd1);

    // TX lock gate
    uart_rate = 8'd0;
    wr_data = 8'h55; wr_en = 1'b1; tick(); wr_en = 1'b0;
    pulses = 0;
    for (int i = 0; i < 5000; i++) begin
      tick();
      if (uart_dox) pulses++;
    end
    chk("gate_no_dox", 32'(pulses), 32'd0);
    chk("gate_queued", 32'(tx_count), 32'd1);
    uart_rate = 8'd4; tick();
    chk("gate_dox", 32'(uart_dox), 32'd1);
    chk("gate_od", 32'(uart_od), 32'h55);
    tick();
    chk("gate_dox_one_cycle", 32'(uart_dox), 32'd0);
    chk("gate_od_hold", 32'(uart_od), 32'h55);
    repeat (500) tick();

    // TX pacing
    uart_rate = 8'd0;
    wr_data = 8'hA0; wr_en = 1'b1; tick();
    wr_data = 8'hA1; tick(); wr_en = 1'b0;
    chk("pace_count2", 32'(tx_count), 32'd2);
    uart_rate = 8'd4; tick();
    chk("pace_dox1", 32'(uart_dox), 32'd1);
    chk("pace_od1", 32'(uart_od), 32'hA0);
    chk("pace_count1", 32'(tx_count), 32'd1);
    n = 0; bad = 0;
    do begin
      tick(); n++;
      if (!uart_dox && uart_od !== 8'hA0) bad++;
    end while (!uart_dox && n < 1000);
    chk("pace_spacing", 32'(n), 32'd440);
    chk("pace_od_hold_errors", 32'(bad), 32'd0);
    chk("pace_od2", 32'(uart_od), 32'hA1);
    chk("pace_count0", 32'(tx_count), 32'd0);
    repeat (500) tick();

    // TX full, then push accepted alongside a pop
    uart_rate = 8'd0;
    for (int b = 0; b < 17; b++) begin
      wr_data = 8'(8'hC0 + b); wr_en = 1'b1; tick();
    end
    wr_en = 1'b0;
    chk("tx_full_flag", 32'(tx_full), 32'd1);
    chk("tx_full_count", 32'(tx_count), 32'd16);
    uart_rate = 8'd4; wr_data = 8'hEE; wr_en = 1'b1; tick(); wr_en = 1'b0;
    chk("tx_full_pushpop_count", 32'(tx_count), 32'd16);
    chk("tx_full_pushpop_od", 32'(uart_od), 32'hC0);

    // Reset mid-GAP with three bytes queued
    nreset = 1'b0; tick(); nreset = 1'b1; tick();
    uart_rate = 8'd0;
    for (int b = 0; b < 4; b++) begin
      wr_data = 8'(8'hB0 + b); wr_en = 1'b1; tick();
    end
    wr_en = 1'b0;
    uart_rate = 8'd4; tick();
    chk("midgap_dox", 32'(uart_dox), 32'd1);
    chk("midgap_queued", 32'(tx_count), 32'd3);
    repeat (100) tick();
    nreset = 1'b0; #1;
    chk("midgap_rst_count", 32'(tx_count), 32'd0);
    chk("midgap_rst_dox", 32'(uart_dox), 32'd0);
    chk("midgap_rst_od", 32'(uart_od), 32'd0);
    tick(); nreset = 1'b1;
    pulses = 0;
    for (int i = 0; i < 1000; i++) begin
      tick();
      if (uart_dox) pulses++;
    end
    chk("midgap_no_pulses", 32'(pulses), 32'd0);

    $display("%0d/%0d checks passed", passed, total);
    $finish;
  end

endmodule

// File: doc/uart_fifo.md
Name: uart_fifo

Overview:
- Buffers bytes between the b16 I/O bus and the auto-bauding UART core.
- RX side captures each received byte on the core's one-cycle receive strobe into a show-ahead FIFO.
- TX side drains a FIFO into the core: one-cycle start pulse, then a frame-length hold-off timed from the core's rate output.
- The core has no busy flag, so frame pacing is this block's job.

Parameters:
- DEPTH_LOG2, 4, log2 of each FIFO depth (16 entries per direction).

Ports:
- clk  in  1  system clock
- nreset  in  1  asynchronous reset, active-low
- uart_id  in  8  received byte from UART core
- uart_dix  in  1  one-cycle strobe, uart_id valid
- uart_rate  in  8  baud divider/8 from core; 0 = baud not yet locked
- uart_od  out  8  byte to transmit
- uart_dox  out  1  one-cycle transmit start pulse
- wr_data  in  8  host byte to transmit
- wr_en  in  1  push wr_data into TX FIFO
- tx_full  out  1  TX FIFO full
- tx_count  out  DEPTH_LOG2+1  TX FIFO occupancy
- rd_data  out  8  RX FIFO head (show-ahead)
- rd_en  in  1  pop RX FIFO head
- rx_empty  out  1  RX FIFO empty
- rx_count  out  DEPTH_LOG2+1  RX FIFO occupancy
- rx_overrun  out  1  sticky: received byte dropped
- ovr_clr  in  1  clear rx_overrun

Behaviour:
- Reset (asynchronous, any time, including mid-frame):
  - FIFOs empty, both counts 0, rx_empty=1, tx_full=0, rx_overrun=0.
  - uart_dox=0, uart_od=0, TX state IDLE, all timers 0.
- FIFOs:
  - Circular, DEPTH_LOG2-bit pointers wrap modulo depth.
  - Count is DEPTH_LOG2+1 bits; full when count == 2^DEPTH_LOG2.
- RX path:
  - uart_dix while not full: write uart_id at the tail on that edge; rx_count +1; rx_empty falls next cycle.
  - rd_data = head entry combinationally; value undefined when empty.
  - rd_en while empty: ignored, no pointer movement.
  - uart_dix while full and no rd_en: byte dropped; rx_overrun=1 from the next cycle.
  - uart_dix and rd_en in the same cycle while full: pop and push both happen; count unchanged; no overrun.
  - uart_dix and rd_en in the same cycle while empty: push only.
  - rx_overrun stays set until ovr_clr. If ovr_clr and a new drop occur in the same cycle, set wins.
- TX FIFO:
  - wr_en while not full: push.
  - wr_en while full: ignored, unless the TX engine pops in the same cycle, in which case the push is accepted.
- TX engine states:
  - IDLE: when tx_count != 0 and uart_rate != 0, on that edge:
    - uart_od <= head, uart_dox <= 1, pop TX FIFO.
    - bit counter <= 0; bit timer <= (uart_rate+1)<<3, 12 bits.
    - Go to GAP.
    - When uart_rate == 0, bytes stay queued; nothing is sent, because the core discards starts before baud lock.
  - GAP:
    - uart_dox <= 0 (pulse is exactly one cycle); uart_od holds.
    - Bit timer decrements each cycle. On reaching 1, it reloads from the current uart_rate and the bit counter increments.
    - When the bit counter reaches 11 (10 frame bits + 1 guard bit), go to IDLE.
  - Pulse spacing: consecutive uart_dox pulses are at least 11*((rate+1)*8) cycles apart. This is ≥ 10 core bit periods, so the core is always idle at dox.
  - Back-to-back: a queued byte starts on the first IDLE cycle.
- Rate change during GAP: takes effect at the next bit boundary only.
- All outputs registered except rd_data, rx_empty, tx_full and the counts, which are decoded from registers.

Test Plan:
- Reset: after nreset deasserts, check rx_empty=1, tx_count=0, uart_dox=0, uart_od=0, rx_overrun=0.
- RX order: pulse uart_dix with 0x41, 0x42, 0x43 → rx_count=3, rd_data=0x41. Three rd_en pops → 0x42, 0x43, then rx_empty=1. An extra rd_en leaves rx_count=0.
- RX overrun: 17 dix strobes (bytes 0x00..0x10) with no reads → rx_count=16, rx_overrun=1, reads return 0x00..0x0F. ovr_clr → 0. Repeat the test with full FIFO plus simultaneous dix and rd_en → no overrun, count stays 16.
- TX lock gate: push 0x55 with uart_rate=0 → no dox for 5000 cycles. Set uart_rate=4 → next cycle a dox pulse of exactly one cycle with uart_od=0x55.
- TX pacing: uart_rate=4, push 0xA0 and 0xA1 → dox pulses exactly 11*40=440 cycles apart. uart_od=0xA0 holds until the second pulse; tx_count goes 2→1→0.
- Reset mid-GAP: assert nreset 100 cycles after a dox while 3 bytes are queued → tx_count=0, uart_dox=0, no further pulses after release.
